// File: rtl/tap_tempo_meter_if.sv
// Tap tempo meter bus: measurement controls in, tempo results out.
interface tap_tempo_meter_if #(
  parameter int unsigned W = 16
);
  logic         enable;
  logic         tap;
  logic [W-1:0] tempo_rate;
  logic         tempo_valid;
  logic         rate_update;
  logic         timeout;

  // Driver of enable/tap, consumer of the tempo results.
  modport master (
    output enable, tap,
    input  tempo_rate, tempo_valid, rate_update, timeout
  );

  // The meter itself.
  modport slave (
    input  enable, tap,
    output tempo_rate, tempo_valid, rate_update, timeout
  );
endinterface

// File: rtl/tap_tempo_meter.sv
// Tap tempo meter: measures spacing of tap rising edges, averages the last
// four intervals and publishes the result as a tempo generator rate.
module tap_tempo_meter #(
  parameter int unsigned TEMPO_RATE_DATA_WIDTH = 16,
  parameter int unsigned MIN_INTERVAL          = 16
) (
  input  logic              clk,
  input  logic              reset,
  tap_tempo_meter_if.slave  bus
);
  localparam int unsigned W        = TEMPO_RATE_DATA_WIDTH;
  localparam int unsigned SW       = W + 2;
  localparam logic [W-1:0] CNT_MAX  = '1;
  localparam logic [W-1:0] QUAL_MIN = W'(MIN_INTERVAL - 1);

  typedef enum logic [1:0] {IDLE, ARMED, TRACKING} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   hist_q [4];
  logic           tap_d;
  logic           rise_c;
  logic           qual_c, load_all_c, shift_in_c, clr_hist_c, to_c;
  logic [SW-1:0]  sum_c;
  logic           stage1_q, stage2_q;
  logic [W-1:0]   avg_q;
  logic [W-1:0]   tempo_rate_q;
  logic           tempo_valid_q, rate_update_q, timeout_q;

  assign rise_c = bus.tap & ~tap_d;

  // Tap delay for edge detection; runs regardless of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tap_d <= 1'b0;
    else       tap_d <= bus.tap;
  end

  // State and interval counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and history control; qualified tap beats timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    qual_c     = 1'b0;
    load_all_c = 1'b0;
    shift_in_c = 1'b0;
    clr_hist_c = 1'b0;
    to_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable && rise_c) begin
          cnt_d   = '0;
          state_d = ARMED;
        end
      end
      ARMED, TRACKING: begin
        if (bus.enable) begin
          if (rise_c && (cnt_q >= QUAL_MIN)) begin
            qual_c     = 1'b1;
            load_all_c = (state_q == ARMED);
            shift_in_c = (state_q == TRACKING);
            cnt_d      = '0;
            state_d    = TRACKING;
          end else if (cnt_q == CNT_MAX) begin
            to_c       = 1'b1;
            clr_hist_c = 1'b1;
            cnt_d      = '0;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Interval history, entry 0 newest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
    end else if (clr_hist_c) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
    end else if (load_all_c) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= cnt_q;
    end else if (shift_in_c) begin
      hist_q[3] <= hist_q[2];
      hist_q[2] <= hist_q[1];
      hist_q[1] <= hist_q[0];
      hist_q[0] <= cnt_q;
    end
  end

  // Full-width sum of the four samples.
  always_comb begin
    sum_c = SW'(hist_q[0]) + SW'(hist_q[1]) + SW'(hist_q[2]) + SW'(hist_q[3]);
  end

  // Two-stage publish pipeline: average, then output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage1_q      <= 1'b0;
      stage2_q      <= 1'b0;
      avg_q         <= '0;
      tempo_rate_q  <= '0;
      tempo_valid_q <= 1'b0;
      rate_update_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      stage1_q      <= qual_c;
      stage2_q      <= stage1_q;
      avg_q         <= W'(sum_c >> 2);
      rate_update_q <= stage2_q;
      timeout_q     <= to_c;
      if (stage2_q) begin
        tempo_rate_q  <= avg_q;
        tempo_valid_q <= 1'b1;
      end
    end
  end

  assign bus.tempo_rate  = tempo_rate_q;
  assign bus.tempo_valid = tempo_valid_q;
  assign bus.rate_update = rate_update_q;
  assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_tap_tempo_meter.sv
// Self-checking bench for tap_tempo_meter with an interval-level reference model.
module tb_tap_tempo_meter;
  localparam int W      = 16;
  localparam int MIN_IV = 16;
  localparam int MAXC   = 65535;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tap_tempo_meter_if #(.W(W)) bus ();

  tap_tempo_meter #(
    .TEMPO_RATE_DATA_WIDTH(W),
    .MIN_INTERVAL(MIN_IV)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_upd    = 0;
  int since    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts enabled cycles between tap edges and schedules
  // each published average two cycles after the tap that produced it.
  typedef struct { int due; int val; } sched_t;
  sched_t sq[$];
  int  cyc = 0;
  int  en_cnt = 0, ref_en = 0;
  int  m_phase = 0;
  bit  m_tap_d = 0;
  int  m_hist[4];
  int  e_rate = 0;
  bit  e_valid = 0, e_upd = 0, e_to = 0;

  always @(posedge clk or posedge rst) begin
    bit rise;
    int ivl, s, sum;
    sched_t t;
    if (rst) begin
      m_phase = 0; m_tap_d = 0; sq.delete();
      e_rate = 0; e_valid = 0; e_upd = 0; e_to = 0;
      en_cnt = 0; ref_en = 0;
      for (int i = 0; i < 4; i++) m_hist[i] = 0;
    end else begin
      cyc++;
      e_upd = 0; e_to = 0;
      if (sq.size() > 0 && sq[0].due == cyc) begin
        e_rate = sq[0].val; e_valid = 1; e_upd = 1;
        void'(sq.pop_front());
      end
      rise = bus.tap && !m_tap_d;
      m_tap_d = bus.tap;
      if (bus.enable) begin
        en_cnt++;
        if (m_phase == 0) begin
          if (rise) begin ref_en = en_cnt; m_phase = 1; end
        end else begin
          ivl = en_cnt - ref_en;
          if (rise && ivl >= MIN_IV) begin
            s = ivl - 1;
            if (m_phase == 1) begin
              for (int i = 0; i < 4; i++) m_hist[i] = s;
            end else begin
              for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
              m_hist[0] = s;
            end
            m_phase = 2;
            ref_en = en_cnt;
            sum = m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3];
            t.due = cyc + 2; t.val = sum / 4;
            sq.push_back(t);
          end else if (ivl - 1 == MAXC) begin
            m_phase = 0; e_to = 1;
            for (int i = 0; i < 4; i++) m_hist[i] = 0;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("tempo_rate", int'(bus.tempo_rate), e_rate);
    chk("tempo_valid", int'(bus.tempo_valid), int'(e_valid));
    chk("rate_update", int'(bus.rate_update), int'(e_upd));
    chk("timeout", int'(bus.timeout), int'(e_to));
    if (bus.rate_update) n_upd++;
  end

  task automatic step();
    @(negedge clk);
    since++;
    bus.tap = 1'b0;
  endtask

  // Raise tap for one cycle n cycles after the previous tap.
  task automatic tap_after(input int n);
    while (since < n) step();
    bus.tap = 1'b1;
    since = 0;
  endtask

  task automatic tap_then_check(input int n, input int exp_rate);
    tap_after(n);
    repeat (3) step();
    chk("lit_rate_update", int'(bus.rate_update), 1);
    chk("lit_tempo_rate", int'(bus.tempo_rate), exp_rate);
    chk("lit_tempo_valid", int'(bus.tempo_valid), 1);
  endtask

  initial begin
    int u0, k;
    bus.enable = 1'b1;
    bus.tap    = 1'b0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tempo_rate", int'(bus.tempo_rate), 0);
    chk("rst_tempo_valid", int'(bus.tempo_valid), 0);
    chk("rst_rate_update", int'(bus.rate_update), 0);
    chk("rst_timeout", int'(bus.timeout), 0);
    rst = 1'b0;
    since = 0;

    // Steady 100-cycle taps.
    tap_after(10);
    tap_then_check(100, 99);
    tap_then_check(100, 99);
    tap_then_check(100, 99);
    tap_then_check(100, 99);

    // Spurious edge 5 cycles after a qualified tap.
    u0 = n_upd;
    tap_after(5);
    tap_then_check(95, 99);
    chk("extra_edge_updates", n_upd - u0, 1);

    // Switch to 200-cycle spacing.
    tap_then_check(200, 124);
    tap_then_check(200, 149);
    tap_then_check(200, 174);
    tap_then_check(200, 199);

    // Reset mid-interval while tracking.
    while (since < 40) step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_tempo_rate", int'(bus.tempo_rate), 0);
    chk("midrst_tempo_valid", int'(bus.tempo_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    since = 0;

    // First tap after reset only arms.
    u0 = n_upd;
    tap_after(30);
    repeat (20) step();
    chk("arm_only_updates", n_upd - u0, 0);
    chk("arm_only_valid", int'(bus.tempo_valid), 0);

    // 50 disabled cycles inside a 150-cycle gap, with an ignored edge.
    bus.enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (i == 10) bus.tap = 1'b1;
    end
    bus.enable = 1'b1;
    tap_then_check(150, 99);

    // Abandon the tap train and wait for the timeout.
    tap_then_check(100, 99);
    k = 0;
    while (!bus.timeout && k < 70000) begin step(); k++; end
    chk("timeout_seen", int'(bus.timeout), 1);
    chk("to_tempo_rate", int'(bus.tempo_rate), 99);
    chk("to_tempo_valid", int'(bus.tempo_valid), 1);

    // A single tap after timeout only re-arms.
    u0 = n_upd;
    tap_after(10);
    repeat (20) step();
    chk("post_to_updates", n_upd - u0, 0);
    chk("post_to_rate", int'(bus.tempo_rate), 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
